// File: rtl/issue_filter.sv
// issue_filter
//   Streams filter_length consecutive 18-bit words from the coefficient memory, starting at
//   filter_base_addr. It presents one word per cycle and assigns each issued word round-robin
//   to one of num_allocators allocators. It honours the allocators' stall request and raises
//   a sticky done once every word has been issued.
//
// Ports
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-high reset
//   filter_length        in   number of words to issue (0..8191), held stable while not done
//   filter_block         in   stall: current word not accepted this cycle
//   filter_read_addr     out  memory read port A address (combinational)
//   filter_read_data     in   memory read data, one cycle after the address
//   filter_data          out  word being offered (pass-through of filter_read_data)
//   filter_valid         out  filter_data holds a filter word
//   filter_issue_counter out  allocator index for the current word
//   filter_blocked       out  filter_valid & filter_block
//   done                 out  all words issued, sticky until reset
module issue_filter #(
  parameter int unsigned num_allocators   = 1,
  parameter logic [15:0] filter_base_addr = 16'd0,
  localparam int unsigned AW = (num_allocators > 1) ? $clog2(num_allocators) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   filter_length,
  input  logic          filter_block,
  output logic [15:0]   filter_read_addr,
  input  logic [17:0]   filter_read_data,
  output logic [17:0]   filter_data,
  output logic          filter_valid,
  output logic [AW-1:0] filter_issue_counter,
  output logic          filter_blocked,
  output logic          done
);

  localparam logic [AW-1:0] LastAlloc = AW'(num_allocators - 1);

  logic [13:0] ptr;
  logic [12:0] cur;
  logic [13:0] fetch_idx;
  logic        issue;
  logic        has_more;
  logic        is_last;

  always_comb begin
    // While stalled, re-read the presented word so the memory output keeps showing it.
    fetch_idx        = (filter_block & filter_valid) ? {1'b0, cur} : ptr;
    filter_read_addr = filter_base_addr + {2'b00, fetch_idx};
    filter_data      = filter_read_data;
    filter_blocked   = filter_valid & filter_block;
    issue            = filter_valid & ~filter_block;
    has_more         = ptr < {1'b0, filter_length};
    is_last          = cur == (filter_length - 13'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr                  <= '0;
      cur                  <= '0;
      filter_valid         <= 1'b0;
      filter_issue_counter <= '0;
      done                 <= 1'b0;
    end else begin
      if (!filter_block) begin
        if (has_more && !done) begin
          cur          <= ptr[12:0];
          ptr          <= ptr + 14'd1;
          filter_valid <= 1'b1;
        end else begin
          filter_valid <= 1'b0;
        end
        if (issue) begin
          filter_issue_counter <= (filter_issue_counter == LastAlloc) ? '0
                                : filter_issue_counter + AW'(1);
        end
      end
      // An empty filter is finished as soon as the first edge after reset arrives.
      if ((issue && is_last) || (filter_length == 13'd0)) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_filter.sv
module tb_issue_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] len_all = 13'd0;
  logic        blk = 1'b0;
  int          sel = 0;

  logic        blk0, blk1, blk2;
  logic [15:0] addr0, addr1, addr2;
  logic [17:0] rd0, rd1, rd2;
  logic [17:0] data0, data1, data2;
  logic        v0, v1, v2;
  logic [0:0]  cnt0, cnt2;
  logic [1:0]  cnt1;
  logic        b0, b1, b2;
  logic        d0, d1, d2;

  logic [17:0] mem [65536];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared coefficient memory, one synchronous read port per instance.
  always @(posedge clk) begin
    rd0 <= mem[addr0];
    rd1 <= mem[addr1];
    rd2 <= mem[addr2];
  end

  issue_filter #(.num_allocators(1), .filter_base_addr(16'h0000)) u0 (
    .clk(clk), .rst(rst), .filter_length(len_all), .filter_block(blk0),
    .filter_read_addr(addr0), .filter_read_data(rd0), .filter_data(data0),
    .filter_valid(v0), .filter_issue_counter(cnt0), .filter_blocked(b0), .done(d0)
  );

  issue_filter #(.num_allocators(3), .filter_base_addr(16'h0100)) u1 (
    .clk(clk), .rst(rst), .filter_length(len_all), .filter_block(blk1),
    .filter_read_addr(addr1), .filter_read_data(rd1), .filter_data(data1),
    .filter_valid(v1), .filter_issue_counter(cnt1), .filter_blocked(b1), .done(d1)
  );

  issue_filter #(.num_allocators(1), .filter_base_addr(16'hFFFE)) u2 (
    .clk(clk), .rst(rst), .filter_length(len_all), .filter_block(blk2),
    .filter_read_addr(addr2), .filter_read_data(rd2), .filter_data(data2),
    .filter_valid(v2), .filter_issue_counter(cnt2), .filter_blocked(b2), .done(d2)
  );

  logic [17:0] sd;
  logic        sv, sblk, sdone;
  logic [1:0]  scnt;

  always_comb begin
    blk0 = 1'b0; blk1 = 1'b0; blk2 = 1'b0;
    sd = data0; sv = v0; sblk = b0; sdone = d0; scnt = {1'b0, cnt0};
    case (sel)
      1: begin
        blk1 = blk;
        sd = data1; sv = v1; sblk = b1; sdone = d1; scnt = cnt1;
      end
      2: begin
        blk2 = blk;
        sd = data2; sv = v2; sblk = b2; sdone = d2; scnt = {1'b0, cnt2};
      end
      default: blk0 = blk;
    endcase
  end

  task automatic test_reset();
    rst = 1'b1;
    blk = 1'b0;
    len_all = 13'd10;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({sv, sdone, scnt, sblk} !== 5'b0) begin
        errors++;
        $display("FAIL reset_state s%0d: got valid=%b done=%b cnt=%0d blocked=%b want all 0",
                 s, sv, sdone, scnt, sblk);
      end
    end
  endtask

  // Reference: the stream is "before first word", "presenting word k", or "done". Word k goes
  // to allocator k mod N and is held until a cycle without block.
  // mode 0: no block, 1: random block, 2: block 5 cycles while word 15 is presented.
  task automatic run_stream(input int s, input int len, input int mode, input int abort_at,
                            input string name);
    int n, base, st, k, stalls, blocked, post, done_cyc;
    logic b, exp_v, aborted;
    logic [15:0] a;
    n = (s == 1) ? 3 : 1;
    base = (s == 0) ? 0 : (s == 1) ? 'h100 : 'hFFFE;
    sel = s;
    blk = 1'b0;
    len_all = 13'(len);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    st = 0; k = 0; stalls = 0; blocked = 0; post = 0; done_cyc = -1; aborted = 1'b0;
    for (int cyc = 0; cyc < len * 4 + 40; cyc++) begin
      case (mode)
        1: b = ($urandom_range(0, 3) == 0);
        2: b = (st == 1 && k == 15 && stalls < 5);
        default: b = 1'b0;
      endcase
      if (mode == 2 && b) stalls++;
      if (b && st != 2) blocked++;
      blk = b;
      #1;
      exp_v = (st == 1);
      checks++;
      if (sv !== exp_v) begin
        errors++;
        $display("FAIL %s valid cyc%0d: got %b want %b", name, cyc, sv, exp_v);
      end
      checks++;
      if (sdone !== (st == 2)) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, sdone, (st == 2));
      end
      checks++;
      if (scnt !== 2'(k % n)) begin
        errors++;
        $display("FAIL %s counter cyc%0d: got %0d want %0d", name, cyc, scnt, k % n);
      end
      checks++;
      if (sblk !== (exp_v & b)) begin
        errors++;
        $display("FAIL %s blocked cyc%0d: got %b want %b", name, cyc, sblk, exp_v & b);
      end
      if (st == 1) begin
        a = 16'(base + k);
        checks++;
        if (sd !== mem[a]) begin
          errors++;
          $display("FAIL %s data word%0d: got %h want %h", name, k, sd, mem[a]);
        end
      end
      if (sdone === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (abort_at >= 0 && st == 1 && k == abort_at) begin
        blk = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sv, sdone, scnt, sblk} !== 5'b0) begin
          errors++;
          $display("FAIL %s async_reset: got valid=%b done=%b cnt=%0d blocked=%b want all 0",
                   name, sv, sdone, scnt, sblk);
        end
        aborted = 1'b1;
        break;
      end
      case (st)
        0: if (len == 0) st = 2; else if (!b) st = 1;
        1: if (!b) begin
          k++;
          if (k == len) st = 2;
        end
        default: post++;
      endcase
      if (post >= 4) break;
      @(negedge clk);
    end
    if (!aborted) begin
      checks++;
      if (post < 4) begin
        errors++;
        $display("FAIL %s timeout: reached word %0d of %0d", name, k, len);
      end
      checks++;
      if (done_cyc != len + 1 + blocked) begin
        errors++;
        $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, len + 1 + blocked);
      end
    end
    blk = 1'b0;
  endtask

  task automatic test_basic();       run_stream(0, 255, 0, -1, "basic");        endtask
  task automatic test_stall();       run_stream(0, 255, 2, -1, "stall");        endtask
  task automatic test_round_robin(); run_stream(1, 7, 0, -1, "round_robin");    endtask
  task automatic test_zero_length(); run_stream(0, 0, 0, -1, "zero_length");    endtask
  task automatic test_wrap();        run_stream(2, 4, 0, -1, "wrap");           endtask

  task automatic test_async_reset();
    run_stream(0, 100, 0, 40, "async_abort");
    run_stream(0, 60, 0, -1, "restart");
  endtask

  task automatic test_back_to_back();
    run_stream(1, 200, 1, -1, "rand_rr");
    run_stream(2, 30, 1, -1, "rand_wrap");
    run_stream(0, 120, 1, -1, "rand_single");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 18'($urandom);
    test_reset();
    test_basic();
    test_stall();
    test_round_robin();
    test_zero_length();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
